// File: rtl/nios_system_loader_pkg.sv
// nios_system_loader_pkg: shared states and word geometry for the memory loader.
package nios_system_loader_pkg;
    localparam int WORD_W = 32;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [2:0] {IDLE, FILL, WRITE, RD_ADDR, RD_DATA, DONE} state_t;
endpackage

// File: rtl/nios_system_loader_packer.sv
// nios_system_loader_packer: assembles little-endian words from a byte stream.
module nios_system_loader_packer
    import nios_system_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [7:0]        i_data,
    output logic              o_last,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_ready
);
    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_word;
    logic              r_word_ready;
    logic              w_accept;
    assign w_accept     = i_en && i_valid && !i_clear;
    assign o_last       = w_accept && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
    assign o_word       = r_word;
    assign o_word_ready = r_word_ready;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_word       <= '0;
            r_word_ready <= 1'b0;
        end else if (i_clear) begin
            r_cnt        <= '0;
            r_word_ready <= 1'b0;
        end else if (w_accept) begin
            r_word[8*r_cnt +: 8] <= i_data;
            r_cnt                <= r_cnt + 1'b1;
            r_word_ready         <= o_last;
        end
    end
endmodule

// File: rtl/nios_system_mem_loader.sv
// nios_system_mem_loader: streams bytes into memory words, reads them back and
// compares the modulo-2^32 sums of written and read data.
module nios_system_mem_loader
    import nios_system_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W:0]           word_count,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [WORD_W-1:0]         wr_sum,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [BYTES_PER_WORD-1:0] mem_byteenable,
    output logic                      mem_chipselect,
    output logic                      mem_write,
    output logic [WORD_W-1:0]         mem_writedata,
    output logic                      mem_clken,
    input  logic [WORD_W-1:0]         mem_readdata
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_base, r_addr;
    logic [ADDR_W:0]   r_count, r_idx;
    logic [WORD_W-1:0] r_wr_sum, r_rd_sum;
    logic              r_error;
    logic [ADDR_W:0]   w_idx_inc;
    logic [WORD_W-1:0] w_rd_next, w_word;
    logic              w_abort, w_end, w_last, w_word_ready, w_clear;

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] idx);
        logic [ADDR_W+1:0] s;
        s = {2'b00, base} + {1'b0, idx};
        return (s >= (ADDR_W+2)'(DEPTH)) ? ADDR_W'(s - (ADDR_W+2)'(DEPTH)) : ADDR_W'(s);
    endfunction

    assign w_abort   = abort && (r_state != IDLE);
    assign w_end     = r_idx == (r_count - (ADDR_W+1)'(1));
    assign w_idx_inc = r_idx + (ADDR_W+1)'(1);
    assign w_rd_next = r_rd_sum + mem_readdata;
    assign w_clear   = w_abort || (start && r_state == IDLE);

    nios_system_loader_packer u_packer (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (w_clear),
        .i_en         (s_ready),
        .i_valid      (s_valid),
        .i_data       (s_data),
        .o_last       (w_last),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    assign s_ready        = r_state == FILL;
    assign busy           = r_state != IDLE;
    assign done           = r_state == DONE;
    assign error          = r_error;
    assign wr_sum         = r_wr_sum;
    assign mem_address    = r_addr;
    assign mem_chipselect = (r_state == WRITE) || (r_state == RD_ADDR) || (r_state == RD_DATA);
    assign mem_write      = (r_state == WRITE) && w_word_ready;
    assign mem_byteenable = {BYTES_PER_WORD{mem_write}};
    assign mem_writedata  = w_word;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_addr   <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_wr_sum <= '0;
            r_rd_sum <= '0;
            r_error  <= 1'b0;
        end else if (w_abort) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_error <= 1'b0;
                    if (word_count == '0) begin
                        r_state <= DONE;
                    end else begin
                        r_base   <= base_addr;
                        r_count  <= word_count;
                        r_idx    <= '0;
                        r_wr_sum <= '0;
                        r_rd_sum <= '0;
                        r_state  <= FILL;
                    end
                end
                FILL: if (w_last) begin
                    r_addr  <= wrap_addr(r_base, r_idx);
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_wr_sum <= r_wr_sum + w_word;
                    r_idx    <= w_end ? '0 : w_idx_inc;
                    r_addr   <= w_end ? wrap_addr(r_base, '0) : r_addr;
                    r_state  <= w_end ? RD_ADDR : FILL;
                end
                RD_ADDR: r_state <= RD_DATA;
                RD_DATA: begin
                    r_rd_sum <= w_rd_next;
                    if (w_end) begin
                        // last readback: compare with the sum including this word
                        r_error <= w_rd_next != r_wr_sum;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= w_idx_inc;
                        r_addr  <= wrap_addr(r_base, w_idx_inc);
                        r_state <= RD_ADDR;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
